// File: rtl/hack_computer.sv
// Hack 16-bit computer: ROM32K instruction store, single-cycle CPU and a RAM16K/screen/keyboard data space.
// Build macro SCREEN_EN adds the screen buffer at 0x4000-0x5FFF; without it that range reads 0 and ignores writes.

module hack_rom (
    input  logic        clk_i,
    input  logic [14:0] addr_i,
    output logic [15:0] data_o,
    input  logic        load_en_i,
    input  logic [14:0] load_addr_i,
    input  logic [15:0] load_data_i
);
    logic [15:0] m [0:32767];

    // Programming port; tied off in this top, programs arrive by preloading m.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            m[load_addr_i] <= load_data_i;
        end
    end

    assign data_o = m[addr_i];
endmodule

module hack_dmem #(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    input  logic          we_i,
    output logic [15:0]   rdata_o
);
    logic [15:0] m [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            m[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = m[addr_i];
endmodule

module hack_memory (
    input  logic        clk_i,
    input  logic [14:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        we_i,
    output logic [15:0] rdata_o
);
    logic        ram_sel;
    logic        scr_sel;
    logic [15:0] ram_rdata;
    logic [15:0] scr_rdata;

    assign ram_sel = ~addr_i[14];
    assign scr_sel = (addr_i[14:13] == 2'b10);

    hack_dmem #(.AW(14)) ram16k (
        .clk_i   (clk_i),
        .addr_i  (addr_i[13:0]),
        .wdata_i (wdata_i),
        .we_i    (we_i & ram_sel),
        .rdata_o (ram_rdata)
    );

`ifdef SCREEN_EN
    hack_dmem #(.AW(13)) screen (
        .clk_i   (clk_i),
        .addr_i  (addr_i[12:0]),
        .wdata_i (wdata_i),
        .we_i    (we_i & scr_sel),
        .rdata_o (scr_rdata)
    );
`else
    assign scr_rdata = 16'h0000;
`endif

    // Keyboard (0x6000) and everything above it read as zero.
    always_comb begin
        rdata_o = 16'h0000;
        if (ram_sel) begin
            rdata_o = ram_rdata;
        end else if (scr_sel) begin
            rdata_o = scr_rdata;
        end
    end
endmodule

module hack_cpu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] instr_i,
    input  logic [15:0] in_m_i,
    output logic [15:0] out_m_o,
    output logic        write_m_o,
    output logic [14:0] address_m_o,
    output logic [14:0] pc_o
);
    typedef struct packed {
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } alu_res_t;

    function automatic alu_res_t alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                     input logic [5:0] ctl);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        alu_res_t    res;
        x = ctl[5] ? 16'h0000 : x_in;
        if (ctl[4]) x = ~x;
        y = ctl[3] ? 16'h0000 : y_in;
        if (ctl[2]) y = ~y;
        r = ctl[1] ? (x + y) : (x & y);
        if (ctl[0]) r = ~r;
        res.out = r;
        res.zr  = (r == 16'h0000);
        res.ng  = r[15];
        return res;
    endfunction

    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;
    logic [15:0] y_op;
    logic [15:0] outDR;
    logic        write_m;
    logic        jump_take;
    alu_res_t    alu_r;

    assign y_op  = instr_i[12] ? in_m_i : a_q;
    assign alu_r = alu(d_q, y_op, instr_i[11:6]);
    assign outDR = d_q;

    // Jump target and M address both come from the pre-edge A.
    always_comb begin
        a_d       = a_q;
        d_d       = d_q;
        pc_d      = pc_q + 15'd1;
        write_m   = 1'b0;
        jump_take = 1'b0;
        if (!instr_i[15]) begin
            a_d = {1'b0, instr_i[14:0]};
        end else begin
            if (instr_i[5]) a_d = alu_r.out;
            if (instr_i[4]) d_d = alu_r.out;
            write_m   = instr_i[3];
            jump_take = (instr_i[2] & alu_r.ng)
                      | (instr_i[1] & alu_r.zr)
                      | (instr_i[0] & ~alu_r.ng & ~alu_r.zr);
            if (jump_take) pc_d = a_q[14:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            pc_q <= 15'd0;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign out_m_o     = alu_r.out;
    assign write_m_o   = write_m & rst_ni;
    assign address_m_o = a_q[14:0];
    assign pc_o        = pc_q;
endmodule

module hack_computer (
    input logic clock,
    input logic reset
);
    logic [14:0] pc;
    logic [15:0] I;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic [15:0] inM;
    logic        writeM;

    hack_rom rom (
        .clk_i       (clock),
        .addr_i      (pc),
        .data_o      (I),
        .load_en_i   (1'b0),
        .load_addr_i (15'd0),
        .load_data_i (16'h0000)
    );

    hack_cpu cpu (
        .clk_i       (clock),
        .rst_ni      (reset),
        .instr_i     (I),
        .in_m_i      (inM),
        .out_m_o     (outM),
        .write_m_o   (writeM),
        .address_m_o (addressM),
        .pc_o        (pc)
    );

    hack_memory ram (
        .clk_i   (clock),
        .addr_i  (addressM),
        .wdata_i (outM),
        .we_i    (writeM),
        .rdata_o (inM)
    );
endmodule

// File: tb/tb_hack_computer.sv
// Program-level bench for hack_computer: directed programs plus random programs run against an ISA-level model.
module tb_hack_computer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hack_computer dut (.clock(clock), .reset(reset));

    always #5 clock = ~clock;

    // Comp mnemonics: X = D, Y = A or M depending on the a bit.
    localparam int C_ZERO = 0, C_ONE = 1, C_NEG1 = 2, C_X = 3, C_Y = 4, C_NOTX = 5, C_NOTY = 6;
    localparam int C_NEGX = 7, C_NEGY = 8, C_XP1 = 9, C_YP1 = 10, C_XM1 = 11, C_YM1 = 12;
    localparam int C_XPY = 13, C_XMY = 14, C_YMX = 15, C_XANDY = 16, C_XORY = 17;
    localparam logic [2:0] DM = 3'b001, DD = 3'b010, DA = 3'b100, DAM = 3'b101, DN = 3'b000;
    localparam logic [2:0] JN = 3'b000, JGT = 3'b001, JEQ = 3'b010, JLT = 3'b100, JLE = 3'b110, JMP = 3'b111;

    logic [15:0] prog [0:32767];
    logic [15:0] mram [0:16383];
    logic [15:0] mscr [0:8191];
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;

    function automatic logic [5:0] comp_code(input int idx);
        case (idx)
            C_ZERO:  return 6'b101010;  C_ONE:   return 6'b111111;  C_NEG1:  return 6'b111010;
            C_X:     return 6'b001100;  C_Y:     return 6'b110000;  C_NOTX:  return 6'b001101;
            C_NOTY:  return 6'b110001;  C_NEGX:  return 6'b001111;  C_NEGY:  return 6'b110011;
            C_XP1:   return 6'b011111;  C_YP1:   return 6'b110111;  C_XM1:   return 6'b001110;
            C_YM1:   return 6'b110010;  C_XPY:   return 6'b000010;  C_XMY:   return 6'b010011;
            C_YMX:   return 6'b000111;  C_XANDY: return 6'b000000;  default: return 6'b010101;
        endcase
    endfunction

    function automatic int comp_idx(input logic [5:0] code);
        for (int k = 0; k < 18; k++) if (comp_code(k) == code) return k;
        return C_ZERO;
    endfunction

    function automatic logic [15:0] comp_eval(input int idx, input logic [15:0] x, input logic [15:0] y);
        case (idx)
            C_ZERO: return 16'd0;     C_ONE:  return 16'd1;     C_NEG1: return 16'hFFFF;
            C_X:    return x;         C_Y:    return y;         C_NOTX: return ~x;
            C_NOTY: return ~y;        C_NEGX: return 16'd0 - x; C_NEGY: return 16'd0 - y;
            C_XP1:  return x + 16'd1; C_YP1:  return y + 16'd1; C_XM1:  return x - 16'd1;
            C_YM1:  return y - 16'd1; C_XPY:  return x + y;     C_XMY:  return x - y;
            C_YMX:  return y - x;     C_XANDY: return x & y;    default: return x | y;
        endcase
    endfunction

    function automatic logic [15:0] ai(input int v);
        logic [15:0] w;
        w = v[15:0];
        return {1'b0, w[14:0]};
    endfunction

    function automatic logic [15:0] ci(input logic a, input int idx, input logic [2:0] dst, input logic [2:0] jmp);
        return {3'b111, a, comp_code(idx), dst, jmp};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [14:0] addr);
        if (addr < 15'h4000) return mram[addr[13:0]];
`ifdef SCREEN_EN
        if (addr < 15'h6000) return mscr[addr[12:0]];
`endif
        return 16'h0000;
    endfunction

    task automatic mem_wr(input logic [14:0] addr, input logic [15:0] v);
        if (addr < 15'h4000) mram[addr[13:0]] = v;
`ifdef SCREEN_EN
        else if (addr < 15'h6000) mscr[addr[12:0]] = v;
`endif
    endtask

    task automatic model_step();
        logic [15:0] ins, y, res, old_a;
        logic        take;
        ins   = prog[m_pc];
        old_a = m_a;
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            y   = ins[12] ? mem_rd(old_a[14:0]) : old_a;
            res = comp_eval(comp_idx(ins[11:6]), m_d, y);
            if (ins[3]) mem_wr(old_a[14:0], res);
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            take = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'd0) || (ins[0] && $signed(res) > 0);
            m_pc = take ? old_a[14:0] : m_pc + 15'd1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input int addr, input logic [15:0] w);
        dut.rom.m[addr] <= w;
        prog[addr] = w;
    endtask

    task automatic poke(input int addr, input logic [15:0] v);
        dut.ram.ram16k.m[addr] <= v;
        mram[addr] = v;
    endtask

    task automatic enter_reset();
        @(negedge clock);
        reset = 1'b0;
        m_pc = 15'd0; m_a = 16'd0; m_d = 16'd0;
        for (int i = 0; i < 64; i++) put(i, 16'h0000);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("reset_pc", {1'b0, dut.pc}, 16'd0);
        check("reset_a", {1'b0, dut.addressM}, 16'd0);
        check("reset_d", dut.cpu.outDR, 16'd0);

        // Arithmetic and store.
        enter_reset();
        put(0, ai(2)); put(1, ci(0, C_Y, DD, JN)); put(2, ai(3));
        put(3, ci(0, C_XPY, DD, JN)); put(4, ai(0)); put(5, ci(0, C_X, DM, JN));
        release_reset();
        run(6);
        check("add_m0", dut.ram.ram16k.m[0], 16'd5);
        check("add_d", dut.cpu.outDR, 16'd5);

        // Multiply R0*R1 into R2.
        enter_reset();
        poke(0, 16'd3); poke(1, 16'd4); poke(2, 16'd99);
        put(0, ai(2)); put(1, ci(0, C_ZERO, DM, JN)); put(2, ai(1)); put(3, ci(1, C_Y, DD, JN));
        put(4, ai(14)); put(5, ci(0, C_X, DN, JLE)); put(6, ai(0)); put(7, ci(1, C_Y, DD, JN));
        put(8, ai(2)); put(9, ci(1, C_XPY, DM, JN)); put(10, ai(1)); put(11, ci(1, C_YM1, DM, JN));
        put(12, ai(2)); put(13, ci(0, C_ZERO, DN, JMP)); put(14, ai(14)); put(15, ci(0, C_ZERO, DN, JMP));
        release_reset();
        run(100);
        check("mult_m2", dut.ram.ram16k.m[2], 16'd12);
        check("mult_m1", dut.ram.ram16k.m[1], 16'd0);
        check("mult_park", {15'd0, (dut.pc == 15'd14 || dut.pc == 15'd15)}, 16'd1);

        // Jumps: JLT on negative D.
        enter_reset();
        put(0, ci(0, C_NEG1, DD, JN)); put(1, ai(10)); put(2, ci(0, C_X, DN, JLT));
        release_reset();
        run(3);
        check("jlt_taken", {1'b0, dut.pc}, 16'd10);

        // D=0: JGT falls through, JEQ taken, JMP always taken.
        enter_reset();
        put(0, ci(0, C_ZERO, DD, JN)); put(1, ai(20)); put(2, ci(0, C_X, DN, JGT));
        put(3, ci(0, C_X, DN, JEQ)); put(20, ai(30)); put(21, ci(0, C_ZERO, DN, JMP));
        release_reset();
        run(3);
        check("jgt_not_taken", {1'b0, dut.pc}, 16'd3);
        run(1);
        check("jeq_taken", {1'b0, dut.pc}, 16'd20);
        run(2);
        check("jmp_taken", {1'b0, dut.pc}, 16'd30);

        // AM=M+1 with A=5: memory written at the old A.
        enter_reset();
        poke(5, 16'd41);
        put(0, ai(5)); put(1, ci(1, C_YP1, DAM, JN));
        release_reset();
        run(2);
        check("am_mem", dut.ram.ram16k.m[5], 16'd42);
        check("am_a", {1'b0, dut.addressM}, 16'd42);

        // Screen write/read, then keyboard reads zero and ignores writes.
        enter_reset();
        poke(0, 16'h1234);
        put(0, ai(7)); put(1, ci(0, C_Y, DD, JN)); put(2, ai(16384)); put(3, ci(0, C_NEG1, DM, JN));
        put(4, ci(1, C_Y, DD, JN)); put(5, ai(24576)); put(6, ci(0, C_ONE, DM, JN)); put(7, ci(1, C_Y, DD, JN));
        release_reset();
        run(5);
`ifdef SCREEN_EN
        check("scr_mem", dut.ram.screen.m[0], 16'hFFFF);
        check("scr_read", dut.cpu.outDR, 16'hFFFF);
`else
        check("scr_read", dut.cpu.outDR, 16'h0000);
`endif
        check("scr_ram0", dut.ram.ram16k.m[0], 16'h1234);
        run(3);
        check("kbd_read", dut.cpu.outDR, 16'h0000);

        // pc wraps from 0x7FFF to 0.
        enter_reset();
        put(0, ai(32767)); put(1, ci(0, C_ZERO, DN, JMP)); put(32767, ai(5));
        release_reset();
        run(2);
        check("wrap_top", {1'b0, dut.pc}, 16'h7FFF);
        run(1);
        check("wrap_pc", {1'b0, dut.pc}, 16'd0);
        check("wrap_a", {1'b0, dut.addressM}, 16'd5);

        // Reset mid-run at pc=7.
        enter_reset();
        put(32767, 16'h0000);
        put(0, ai(100)); put(1, ci(0, C_Y, DD, JN)); put(2, ai(50)); put(3, ci(0, C_X, DM, JN));
        for (int i = 4; i < 12; i++) put(i, ci(0, C_XP1, DD, JN));
        release_reset();
        run(7);
        check("mid_pc7", {1'b0, dut.pc}, 16'd7);
        check("mid_d", dut.cpu.outDR, 16'd103);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pc", {1'b0, dut.pc}, 16'd0);
        check("mid_rst_a", {1'b0, dut.addressM}, 16'd0);
        check("mid_rst_d", dut.cpu.outDR, 16'd0);
        run(1);
        check("mid_hold_pc", {1'b0, dut.pc}, 16'd0);
        check("mid_ram", dut.ram.ram16k.m[50], 16'd100);
        release_reset();
        run(2);
        check("mid_restart_pc", {1'b0, dut.pc}, 16'd2);
        check("mid_restart_d", dut.cpu.outDR, 16'd100);

        // Random programs against the ISA model.
        for (int pass = 0; pass < 2; pass++) begin
            enter_reset();
            for (int i = 0; i < 32768; i++) put(i, 16'h0000);
            for (int i = 0; i < 16384; i++) poke(i, 16'h0000);
`ifdef SCREEN_EN
            for (int i = 0; i < 8192; i++) begin dut.ram.screen.m[i] <= 16'h0000; mscr[i] = 16'h0000; end
`endif
            for (int i = 0; i < 200; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 4) begin
                    case ($urandom_range(0, 5))
                        0, 1: put(i, ai(int'($urandom_range(0, 15))));
                        2:    put(i, ai(16384 + int'($urandom_range(0, 7))));
                        3:    put(i, ai(24576 + int'($urandom_range(0, 2))));
                        4:    put(i, ai(int'($urandom_range(0, 199))));
                        default: put(i, ai(int'($urandom_range(0, 32767))));
                    endcase
                end else begin
                    logic [2:0] dst, jmp;
                    dst = 3'($urandom_range(0, 7));
                    jmp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                    put(i, ci(1'($urandom_range(0, 1)), int'($urandom_range(0, 17)), dst, jmp));
                end
            end
            release_reset();
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(posedge clock);
                model_step();
                #1;
                check("rnd_pc", {1'b0, dut.pc}, {1'b0, m_pc});
                check("rnd_a", {1'b0, dut.addressM}, {1'b0, m_a[14:0]});
                check("rnd_d", dut.cpu.outDR, m_d);
            end
            begin
                int diffs;
                diffs = 0;
                for (int i = 0; i < 16384; i++) if (dut.ram.ram16k.m[i] !== mram[i]) diffs++;
                check("rnd_ram_diffs", diffs[15:0], 16'd0);
`ifdef SCREEN_EN
                diffs = 0;
                for (int i = 0; i < 8192; i++) if (dut.ram.screen.m[i] !== mscr[i]) diffs++;
                check("rnd_scr_diffs", diffs[15:0], 16'd0);
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hack_computer.md
# hack_computer

Top-level Hack-style 16-bit computer: a ROM32K instruction memory, a single-cycle CPU (A/D registers, program counter, ALU) and a memory-mapped data space (RAM16K, screen buffer, keyboard word). The block has no functional outputs. It runs whatever program is preloaded into its instruction ROM, and results are observed through hierarchical probes. It is the root of the hardware hierarchy, and program-level benches instantiate it directly.

## Interface
- Parameters: none.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Probe-visible hierarchy (names are fixed and benches depend on them):
  - rom.m[0:32767]: 16-bit instruction words, loadable by $readmemb.
  - pc: 15-bit program counter.
  - I: current instruction.
  - addressM: A[14:0].
  - outM: ALU output.
  - cpu.outDR: D register.
  - ram.ram16k.m[0:16383] and ram.screen.m[0:8191]: 16-bit data memories.

## Operation
- Fetch: I = rom.m[pc], read combinationally.
- A-instruction (I[15]=0): A <= {1'b0, I[14:0]}.
- C-instruction (I[15:13]=111):
  - a=I[12] selects the ALU y operand: 0 selects A, 1 selects M = data[A[14:0]].
  - x operand = D.
- ALU control bits zx,nx,zy,ny,f,no = I[11:6], applied in order:
  - zx zeroes x; nx inverts x; zy zeroes y; ny inverts y.
  - f=1 gives x+y (mod 2^16); f=0 gives x&y.
  - no inverts the result.
  - Flags: zr = (out==0); ng = out[15].
- Destinations d1,d2,d3 = I[5:3] load A, D, M respectively, each with outM. Any combination is allowed.
- Jump bits j1,j2,j3 = I[2:0] test lt (ng), eq (zr), gt (!ng&&!zr). Jump taken if any selected condition holds: pc <= A[14:0]. Otherwise pc <= pc+1.
- Instructions with I[15]=0 never write D or M and never jump. For I[15]=1, I[14:13] are ignored.
- Data map (15-bit address):
  - 0x0000–0x3FFF: RAM16K.
  - 0x4000–0x5FFF: screen.
  - 0x6000: keyboard, reads 0 (no keyboard input port).
  - Above 0x6000: reads 0, writes ignored.
- Reads of RAM and screen are asynchronous; writes are synchronous.

## Timing
- Single-cycle: every instruction completes on one rising edge.
- Simultaneous updates in one instruction:
  - M write, jump target and the M operand all use the pre-edge A.
  - A, D, M and pc update on the same edge.
- pc wraps 0x7FFF -> 0x0000 on increment.
- Reset (reset=0, asynchronous): pc=0, A=0, D=0 immediately, held while asserted; no memory writes while reset is asserted. RAM, screen and ROM contents are preserved.
- Deassertion: the first instruction, rom.m[0], executes on the first rising edge with reset=1. Reset asserted mid-program aborts the program at once.

## Configuration
- SCREEN_EN:
  - Defined: screen memory ram.screen.m is present at 0x4000–0x5FFF.
  - Undefined: the screen is removed; that range reads 0 and writes are ignored; RAM16K behaviour is unchanged.

## Test plan
- Arithmetic and store: program @2; D=A; @3; D=D+A; @0; M=D, with reset pulse → ram.ram16k.m[0]=5 after 6 post-reset edges; cpu.outDR=5.
- Multiply: mult program (loops adding R0 into R2 R1 times) with m[0]=3, m[1]=4 preloaded → m[2]=12, then the program parks in its terminal infinite loop.
- Jumps: D=-1 then @10; D;JLT → pc=10. With D=0, D;JGT is not taken (pc+1) and D;JEQ is taken. 0;JMP is always taken.
- Simultaneous dest: A=5, then AM=M+1 → old m[5]+1 written to m[5], A = that value.
- Screen: @16384; M=-1 → ram.screen.m[0]=0xFFFF with SCREEN_EN defined. Without it, nothing is written, the word reads 0 and m[0] of RAM is unchanged.
- Reset mid-run: drop reset while pc=7, async → pc=0, A=0, D=0 immediately with no clock edge; RAM is preserved and execution restarts at 0 after release.
